// File: rtl/bus_pkg.sv
// Shared bus encodings: owner codes and arbiter FSM states.
// Also used by the bus controller.
package bus_pkg;
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_M68  = 2'd1,
      OWN_Z80  = 2'd2,
      OWN_VDP  = 2'd3
   } owner_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_RELEASE = 2'd2
   } state_e;

   // Encoding of the round-robin memory bit (which CPU was granted last)
   localparam logic LAST_M68 = 1'b0;
   localparam logic LAST_Z80 = 1'b1;
endpackage

// File: rtl/ram_arbiter_if.sv
// Request/grant bundle between the three bus masters and the RAM arbiter.
interface ram_arbiter_if;
   logic       vdp_req;
   logic       m68_req;
   logic       z80_req;
   logic       vdp_done;
   logic       m68_done;
   logic       z80_done;
   logic       vdp_gnt;
   logic       m68_gnt;
   logic       z80_gnt;
   logic [1:0] owner;
   logic       busy;
   logic       timeout_err;

   modport master (
      output vdp_req, m68_req, z80_req, vdp_done, m68_done, z80_done,
      input  vdp_gnt, m68_gnt, z80_gnt, owner, busy, timeout_err
   );

   modport slave (
      input  vdp_req, m68_req, z80_req, vdp_done, m68_done, z80_done,
      output vdp_gnt, m68_gnt, z80_gnt, owner, busy, timeout_err
   );
endinterface

// File: rtl/arb_pick.sv
// Combinational winner selection: VDP fixed priority, M68/Z80 round-robin.
module arb_pick
   import bus_pkg::*;
(
   input  logic [2:0] i_req,       // {vdp, z80, m68}
   input  logic       i_last_cpu,
   output owner_e     o_owner
);

   always_comb begin
      o_owner = OWN_NONE;
      if (i_req[2]) begin
         o_owner = OWN_VDP;
      end else if (i_req[1] && i_req[0]) begin
         // On a tie the CPU that was not served last wins
         o_owner = (i_last_cpu == LAST_Z80) ? OWN_M68 : OWN_Z80;
      end else if (i_req[0]) begin
         o_owner = OWN_M68;
      end else if (i_req[1]) begin
         o_owner = OWN_Z80;
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// Three-master RAM arbiter: IDLE -> GRANT -> RELEASE with hold timeout.
// All outputs are flops fed from next-state values.
module ram_arbiter
   import bus_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   ram_arbiter_if.slave  bus
);

   state_e             r_state, w_state_nxt;
   owner_e             r_owner, w_owner_nxt, w_pick;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic               r_last_cpu, w_last_nxt;
   logic               r_tmo, w_tmo_nxt;
   logic               r_vdp_gnt, r_m68_gnt, r_z80_gnt, r_busy;
   logic [2:0]         w_req;
   logic               w_own_req, w_own_done, w_hit_tmo;

   assign w_req     = {bus.vdp_req, bus.z80_req, bus.m68_req};
   assign w_hit_tmo = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   arb_pick u_pick (
      .i_req      (w_req),
      .i_last_cpu (r_last_cpu),
      .o_owner    (w_pick)
   );

   // Only the current owner's req/done are observed
   always_comb begin
      w_own_req  = 1'b0;
      w_own_done = 1'b0;
      case (r_owner)
         OWN_M68: begin w_own_req = bus.m68_req; w_own_done = bus.m68_done; end
         OWN_Z80: begin w_own_req = bus.z80_req; w_own_done = bus.z80_done; end
         OWN_VDP: begin w_own_req = bus.vdp_req; w_own_done = bus.vdp_done; end
         default: begin w_own_req = 1'b0;        w_own_done = 1'b0;         end
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      w_cnt_nxt   = r_cnt;
      w_last_nxt  = r_last_cpu;
      w_tmo_nxt   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_owner_nxt = w_pick;
            if (w_pick != OWN_NONE) begin
               w_state_nxt = ST_GRANT;
               w_cnt_nxt   = '0;
               if (w_pick == OWN_M68) w_last_nxt = LAST_M68;
               if (w_pick == OWN_Z80) w_last_nxt = LAST_Z80;
            end
         end
         ST_GRANT: begin
            if (w_own_done || !w_own_req || w_hit_tmo) begin
               w_state_nxt = ST_RELEASE;
               w_owner_nxt = OWN_NONE;
               // Error only when the timeout alone forced the release
               w_tmo_nxt   = w_hit_tmo && !w_own_done && w_own_req;
            end else if (r_cnt != '1) begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         ST_RELEASE: begin
            w_state_nxt = ST_IDLE;
            w_owner_nxt = OWN_NONE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_owner_nxt = OWN_NONE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_owner    <= OWN_NONE;
         r_cnt      <= '0;
         r_last_cpu <= LAST_Z80;
         r_tmo      <= 1'b0;
         r_vdp_gnt  <= 1'b0;
         r_m68_gnt  <= 1'b0;
         r_z80_gnt  <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_owner    <= w_owner_nxt;
         r_cnt      <= w_cnt_nxt;
         r_last_cpu <= w_last_nxt;
         r_tmo      <= w_tmo_nxt;
         r_vdp_gnt  <= (w_owner_nxt == OWN_VDP);
         r_m68_gnt  <= (w_owner_nxt == OWN_M68);
         r_z80_gnt  <= (w_owner_nxt == OWN_Z80);
         r_busy     <= (w_state_nxt != ST_IDLE);
      end
   end

   assign bus.vdp_gnt     = r_vdp_gnt;
   assign bus.m68_gnt     = r_m68_gnt;
   assign bus.z80_gnt     = r_z80_gnt;
   assign bus.owner       = r_owner;
   assign bus.busy        = r_busy;
   assign bus.timeout_err = r_tmo;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: one instance at default timeout, one at TIMEOUT_CYCLES=4.
// Each step queues the outputs expected after the next edge; a monitor pops and compares.
module tb_ram_arbiter;

   logic       clk = 1'b0;
   logic       r_rst_n = 1'b0;
   logic [2:0] r_req  = 3'b000;   // {vdp, z80, m68}
   logic [2:0] r_done = 3'b000;

   int n_checks = 0;
   int n_fail   = 0;

   string      tag_q[$];
   logic       sel_q[$];
   logic [6:0] exp_q[$];

   ram_arbiter_if ifa ();
   ram_arbiter_if ifb ();

   assign ifa.vdp_req  = r_req[2];
   assign ifa.z80_req  = r_req[1];
   assign ifa.m68_req  = r_req[0];
   assign ifa.vdp_done = r_done[2];
   assign ifa.z80_done = r_done[1];
   assign ifa.m68_done = r_done[0];
   assign ifb.vdp_req  = r_req[2];
   assign ifb.z80_req  = r_req[1];
   assign ifb.m68_req  = r_req[0];
   assign ifb.vdp_done = r_done[2];
   assign ifb.z80_done = r_done[1];
   assign ifb.m68_done = r_done[0];

   ram_arbiter u_dut_a (
      .clk   (clk),
      .rst_n (r_rst_n),
      .bus   (ifa.slave)
   );

   ram_arbiter #(.TIMEOUT_CYCLES(4), .CNT_W(8)) u_dut_b (
      .clk   (clk),
      .rst_n (r_rst_n),
      .bus   (ifb.slave)
   );

   always #5 clk = ~clk;

   logic [6:0] obs_a, obs_b;
   assign obs_a = {ifa.vdp_gnt, ifa.z80_gnt, ifa.m68_gnt, ifa.owner, ifa.busy, ifa.timeout_err};
   assign obs_b = {ifb.vdp_gnt, ifb.z80_gnt, ifb.m68_gnt, ifb.owner, ifb.busy, ifb.timeout_err};

   task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got {gnt vzm,owner,busy,tmo}=%b want %b", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] pack(input logic [1:0] own, input logic b, input logic t);
      return {own == 2'd3, own == 2'd2, own == 2'd1, own, b, t};
   endfunction

   // Drive one cycle of inputs and queue the outputs expected after the next edge
   task automatic step(input logic rn, input logic [2:0] req, input logic [2:0] dn,
                       input logic sel, input logic [1:0] eown, input logic ebusy,
                       input logic etmo, input string tag);
      @(negedge clk);
      r_rst_n = rn;
      r_req   = req;
      r_done  = dn;
      tag_q.push_back(tag);
      sel_q.push_back(sel);
      exp_q.push_back(pack(eown, ebusy, etmo));
   endtask

   string      m_tag;
   logic       m_sel;
   logic [6:0] m_exp;

   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         m_tag = tag_q.pop_front();
         m_sel = sel_q.pop_front();
         m_exp = exp_q.pop_front();
         check(m_tag, m_sel ? obs_b : obs_a, m_exp);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, pending=%0d", exp_q.size());
      $fatal(1, "watchdog");
   end

   localparam logic A = 1'b0;
   localparam logic B = 1'b1;

   initial begin
      logic [1:0] own;
      logic [2:0] dbit;

      // Reset state
      step(0, 3'b000, 3'b000, A, 2'd0, 0, 0, "rst0");
      step(0, 3'b011, 3'b000, A, 2'd0, 0, 0, "rst_req");

      // Single M68 request, done pulse in cycle 5
      step(1, 3'b001, 3'b000, A, 2'd1, 1, 0, "s1_gnt");
      for (int i = 0; i < 4; i++) step(1, 3'b001, 3'b000, A, 2'd1, 1, 0, $sformatf("s1_hold%0d", i));
      step(1, 3'b001, 3'b001, A, 2'd0, 1, 0, "s1_rel");
      step(1, 3'b000, 3'b000, A, 2'd0, 0, 0, "s1_idle");

      // Tie fairness from a fresh reset: M68, Z80, M68, Z80
      step(0, 3'b000, 3'b000, A, 2'd0, 0, 0, "s2_rst");
      for (int k = 0; k < 4; k++) begin
         own  = (k % 2 == 0) ? 2'd1 : 2'd2;
         dbit = (k % 2 == 0) ? 3'b001 : 3'b010;
         step(1, 3'b011, 3'b000, A, own,  1, 0, $sformatf("s2_gnt%0d", k));
         step(1, 3'b011, 3'b000, A, own,  1, 0, $sformatf("s2_hold%0d", k));
         step(1, 3'b011, dbit,   A, 2'd0, 1, 0, $sformatf("s2_rel%0d", k));
         step(1, 3'b011, 3'b000, A, 2'd0, 0, 0, $sformatf("s2_idle%0d", k));
      end

      // Priority without preemption; VDP grant leaves the round-robin bit alone
      step(1, 3'b010, 3'b000, A, 2'd2, 1, 0, "s3_z80");
      step(1, 3'b110, 3'b000, A, 2'd2, 1, 0, "s3_nopre1");
      step(1, 3'b111, 3'b000, A, 2'd2, 1, 0, "s3_nopre2");
      step(1, 3'b111, 3'b010, A, 2'd0, 1, 0, "s3_rel");
      step(1, 3'b111, 3'b000, A, 2'd0, 0, 0, "s3_idle");
      step(1, 3'b111, 3'b000, A, 2'd3, 1, 0, "s3_vdp");
      step(1, 3'b111, 3'b011, A, 2'd3, 1, 0, "s3_nonown_done");
      step(1, 3'b011, 3'b000, A, 2'd0, 1, 0, "s3_reqlow_rel");
      step(1, 3'b011, 3'b000, A, 2'd0, 0, 0, "s3_idle2");
      step(1, 3'b011, 3'b000, A, 2'd1, 1, 0, "s3_rr_after_vdp");
      step(1, 3'b000, 3'b000, A, 2'd0, 1, 0, "s3_rel2");
      step(1, 3'b000, 3'b000, A, 2'd0, 0, 0, "s3_idle3");

      // Reset in the middle of an M68 grant
      step(1, 3'b001, 3'b000, A, 2'd1, 1, 0, "s4_gnt");
      step(1, 3'b001, 3'b000, A, 2'd1, 1, 0, "s4_hold");
      step(0, 3'b001, 3'b000, A, 2'd0, 0, 0, "s4_rst");
      step(1, 3'b011, 3'b000, A, 2'd1, 1, 0, "s4_first_arb");
      step(1, 3'b000, 3'b000, A, 2'd0, 1, 0, "s4_rel");
      step(1, 3'b000, 3'b000, A, 2'd0, 0, 0, "s4_idle");

      // Timeout with TIMEOUT_CYCLES=4
      step(0, 3'b000, 3'b000, B, 2'd0, 0, 0, "s5_rst");
      step(1, 3'b100, 3'b000, B, 2'd3, 1, 0, "s5_gnt");
      for (int i = 0; i < 3; i++) step(1, 3'b100, 3'b000, B, 2'd3, 1, 0, $sformatf("s5_hold%0d", i));
      step(1, 3'b100, 3'b000, B, 2'd0, 1, 1, "s5_tmo");
      step(1, 3'b100, 3'b000, B, 2'd0, 0, 0, "s5_tmo_clr");
      step(1, 3'b100, 3'b000, B, 2'd3, 1, 0, "s5_regnt");
      step(1, 3'b000, 3'b000, B, 2'd0, 1, 0, "s5_rel");
      step(1, 3'b000, 3'b000, B, 2'd0, 0, 0, "s5_idle");

      // Done coinciding with the timeout cycle
      step(1, 3'b001, 3'b000, B, 2'd1, 1, 0, "s6_gnt");
      for (int i = 0; i < 3; i++) step(1, 3'b001, 3'b000, B, 2'd1, 1, 0, $sformatf("s6_hold%0d", i));
      step(1, 3'b001, 3'b001, B, 2'd0, 1, 0, "s6_done_wins");
      step(1, 3'b000, 3'b000, B, 2'd0, 0, 0, "s6_idle");

      repeat (3) @(negedge clk);
      check("drain", 7'(exp_q.size()), 7'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
